// File: rtl/mux8way_rr.sv
// mux8way_rr: 8-to-1 round-robin merger with a single registered output stage.
// Optional MUX8WAY_STATS_EN adds xfer_count, an 8-bit output handshake counter.
module mux8way_rr #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX8WAY_STATS_EN
    ,
    output logic [7:0]         xfer_count
`endif
);

    logic [2:0]       ptr;
    logic [2:0]       gnt_idx;
    logic             gnt_found;
    logic [2:0]       idx;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] gnt_word;

    // The stage can take a word when it is empty or its word leaves this cycle.
    assign space  = !out_valid || out_ready;
    // The reset cycle never accepts, even when sources are already valid.
    assign accept = rst_n && space && gnt_found;

    // First valid channel at or after ptr, ascending with 7->0 wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 3'd0;
        idx       = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!gnt_found && in_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // One-hot ready to the granted channel only when the word can be taken.
    always_comb begin
        in_ready = 8'b0;
        if (accept) begin
            in_ready = 8'b1 << gnt_idx;
        end
    end

    // Word of the granted channel, taken from its packed slot.
    always_comb begin
        gnt_word = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    end

    // Output stage and pointer: accept overrides drain, stall holds everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 3'd0;
            ptr       <= 3'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gnt_word;
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx + 3'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX8WAY_STATS_EN
    // Count every word that leaves the output stage; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= 8'd0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux8way_rr.sv
// tb_mux8way_rr: directed vectors for the round-robin merger.
// Source hold rule is watched continuously alongside the directed checks.
module tb_mux8way_rr;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;
`ifdef MUX8WAY_STATS_EN
    logic [7:0]         xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    mux8way_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX8WAY_STATS_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int ch, input logic [WIDTH-1:0] v);
        in_data[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [2:0] s, input logic [WIDTH-1:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_sel"},   32'(out_sel),   32'(s));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    // Source rule: a channel left waiting at an edge must still offer the same word.
    logic [7:0]       pend = 8'b0;
    logic [WIDTH-1:0] held [8];
    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 8'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pend[i]) begin
                    chk("hold_valid", 32'(in_valid[i]), 32'd1);
                    chk("hold_data", 32'(in_data[i*WIDTH +: WIDTH]),
                        32'(held[i]));
                end
            end
            pend = in_valid & ~in_ready;
        end
        for (int i = 0; i < 8; i++) held[i] = in_data[i*WIDTH +: WIDTH];
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        in_data   = '0;
        for (int i = 0; i < 8; i++) setd(i, WIDTH'(i));

        // Reset with every channel valid
        #1;
        chk("rst_ready0", 32'(in_ready), 32'h00);
        tick();
        tick();
        chk_out("rst", 1'b0, 3'd0, 4'h0);
        chk("rst_ready", 32'(in_ready), 32'h00);

        // Sweep: two full rounds, second round retires each channel
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("sweep_ready", 32'(in_ready), 32'(8'b1 << (k % 8)));
            tick();
            chk_out("sweep", 1'b1, 3'(k % 8), 4'(k % 8));
            if (k >= 8) in_valid[k % 8] = 1'b0;
        end
        tick();
        chk_out("drain", 1'b0, 3'd7, 4'h7);
        chk("idle_ready", 32'(in_ready), 32'h00);

        // Single channel 5
        setd(5, 4'hA);
        in_valid = 8'b0010_0000;
        #1;
        chk("single_ready", 32'(in_ready), 32'h20);
        tick();
        chk_out("single", 1'b1, 3'd5, 4'hA);
        in_valid = 8'h00;

        // ch2 offered alone; pointer 6 must wrap round to it
        setd(2, 4'h3);
        in_valid = 8'b0000_0100;
        #1;
        chk("ch2_ready", 32'(in_ready), 32'h04);
        tick();
        chk_out("ch2", 1'b1, 3'd2, 4'h3);

        // Backpressure for 4 cycles with ch3 and ch6 waiting
        out_ready = 1'b0;
        setd(3, 4'h9);
        setd(6, 4'hC);
        in_valid = 8'b0100_1000;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("bp_hold", 1'b1, 3'd2, 4'h3);
            chk("bp_ready", 32'(in_ready), 32'h00);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(in_ready), 32'h08);
        tick();
        chk_out("bp_ch3", 1'b1, 3'd3, 4'h9);
        in_valid[3] = 1'b0;
        #1;
        chk("bp_ch6_ready", 32'(in_ready), 32'h40);
        tick();
        chk_out("bp_ch6", 1'b1, 3'd6, 4'hC);
        in_valid = 8'h00;

        // Wrap from ptr 7 with ch1 and ch7
        setd(1, 4'h5);
        setd(7, 4'hE);
        in_valid = 8'b1000_0010;
        #1;
        chk("wrap_ready7", 32'(in_ready), 32'h80);
        tick();
        chk_out("wrap_ch7", 1'b1, 3'd7, 4'hE);
        in_valid[7] = 1'b0;
        #1;
        chk("wrap_ready1", 32'(in_ready), 32'h02);
        tick();
        chk_out("wrap_ch1", 1'b1, 3'd1, 4'h5);

        // ptr should now be 2: ch1 and ch2 offered, ch2 wins
        in_valid = 8'b0000_0110;
        #1;
        chk("ptr2_ready", 32'(in_ready), 32'h04);
        tick();
        chk_out("ptr2", 1'b1, 3'd2, 4'h3);
        in_valid[2] = 1'b0;
        #1;
        chk("ptr3_ch1_ready", 32'(in_ready), 32'h02);
        tick();
        chk_out("ptr3_ch1", 1'b1, 3'd1, 4'h5);
        in_valid = 8'h00;

        // Idle cycles leave ptr at 2: ch0 and ch3 offered, ch3 wins
        tick();
        tick();
        tick();
        chk_out("idle", 1'b0, 3'd1, 4'h5);
        in_valid = 8'b0000_1001;
        #1;
        chk("hold_ptr_ready", 32'(in_ready), 32'h08);
        tick();
        chk_out("hold_ptr", 1'b1, 3'd3, 4'h9);
        in_valid[3] = 1'b0;
        #1;
        chk("ch0_ready", 32'(in_ready), 32'h01);
        tick();
        chk_out("ch0", 1'b1, 3'd0, 4'h0);
        in_valid = 8'h00;

        // Reset while a stalled word is held
        setd(4, 4'h7);
        in_valid = 8'b0001_0000;
        tick();
        chk_out("pre_rst", 1'b1, 3'd4, 4'h7);
        in_valid  = 8'h00;
        out_ready = 1'b0;
        tick();
        chk_out("stall", 1'b1, 3'd4, 4'h7);
        rst_n = 1'b0;
        tick();
        chk_out("mid_rst", 1'b0, 3'd0, 4'h0);
`ifdef MUX8WAY_STATS_EN
        chk("mid_rst_cnt", 32'(xfer_count), 32'd0);
`endif
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 8'b1000_0010;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h02);
        tick();
        chk_out("post_rst_ch1", 1'b1, 3'd1, 4'h5);
        in_valid[1] = 1'b0;
        tick();
        chk_out("post_rst_ch7", 1'b1, 3'd7, 4'hE);
        in_valid = 8'h00;

`ifdef MUX8WAY_STATS_EN
        // 257 output handshakes wrap the counter to 1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("cnt_zero", 32'(xfer_count), 32'd0);
        in_valid = 8'b0000_0001;
        for (int n = 0; n < 258; n++) tick();
        chk("cnt_wrap", 32'(xfer_count), 32'd1);
        in_valid = 8'h00;
        rst_n = 1'b0;
        tick();
        chk("cnt_rst", 32'(xfer_count), 32'd0);
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
